// File: rtl/fft_frame_ctrl_pkg.sv
// Shared FFT control definitions: sequencer state encoding, Avalon-ST error codes, default length.
// Pure declarations; no timing or flow-control behaviour of its own.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Error codes reported by the FFT core on its source interface
  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_MISSING_SOP = 2'b01;
  localparam logic [1:0] ERR_MISSING_EOP = 2'b10;
  localparam logic [1:0] ERR_UNEXP_EOP   = 2'b11;

  localparam int FFT_LEN_DEFAULT = 1024;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Avalon-ST sink/source control handshake between the frame sequencer and the FFT core.
// master = sequencer (drives sink framing), slave = FFT core side.
interface fft_frame_ctrl_if;
  logic       sink_valid;
  logic       sink_ready;
  logic       sink_sop;
  logic       sink_eop;
  logic       source_valid;
  logic       source_eop;
  logic [1:0] source_error;

  modport master (
    output sink_valid, sink_sop, sink_eop,
    input  sink_ready, source_valid, source_eop, source_error
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop,
    output sink_ready, source_valid, source_eop, source_error
  );
endinterface

// File: rtl/fft_frame_ctrl_beat_cnt.sv
// Beat index counter with enable/clear, wrapping to 0 after LAST; last is a combinational compare.
// Index updates one cycle after en; no backpressure of its own (caller gates en).
module fft_beat_cnt #(
  parameter int CNT_W = 16,
  parameter int LAST  = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames samples into FRAME_LEN-beat packets for the FFT sink, one frame in flight, optional gap.
// Framing outputs registered (first beat the cycle after start); sink_ready=0 holds the current beat.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FRAME_LEN  = FFT_LEN_DEFAULT,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_mode,
  fft_frame_ctrl_if.master  fft,
  output logic              sample_adv,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_LEN - 2);

  state_t           state;
  logic             sink_valid;
  logic             sink_sop;
  logic             sink_eop;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] gap_cnt;
  logic             last_beat;
  logic             accept;
  logic             src_eop;

  assign accept           = sink_valid & fft.sink_ready;
  assign sample_adv       = accept;
  assign src_eop          = fft.source_valid & fft.source_eop;
  assign fft.sink_valid   = sink_valid;
  assign fft.sink_sop     = sink_sop;
  assign fft.sink_eop     = sink_eop;

  fft_beat_cnt #(
    .CNT_W (CNT_W),
    .LAST  (FRAME_LEN - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept && (state == ST_FEED)),
    .clr   (state != ST_FEED),
    .idx   (idx),
    .last  (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err        <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (fft.source_valid && (fft.source_error != ERR_NONE)) begin
        err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // An accepted start takes priority over any error seen the same cycle
          if (start) begin
            state      <= ST_FEED;
            sink_valid <= 1'b1;
            sink_sop   <= 1'b1;
            sink_eop   <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
          end
        end

        ST_FEED: begin
          if (accept) begin
            sink_sop <= 1'b0;
            if (last_beat) begin
              state      <= ST_DRAIN;
              sink_valid <= 1'b0;
              sink_eop   <= 1'b0;
            end else begin
              sink_eop <= (idx == PRE_LAST);
            end
          end
        end

        ST_DRAIN: begin
          if (src_eop) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            if (!cont_mode) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (GAP_CYCLES > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state      <= ST_FEED;
              sink_valid <= 1'b1;
              sink_sop   <= 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (cont_mode) begin
              state      <= ST_FEED;
              sink_valid <= 1'b1;
              sink_sop   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: FRAME_LEN=8, GAP_CYCLES=2, FCNT_W=2 so frame_cnt wraps after 4.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int FL = 8;
  localparam int GAP = 2;
  localparam int CW = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cont_mode;
  logic          sample_adv;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic [FW-1:0] frame_cnt;

  fft_frame_ctrl_if ifc();

  fft_frame_ctrl #(
    .FRAME_LEN  (FL),
    .GAP_CYCLES (GAP),
    .CNT_W      (CW),
    .FCNT_W     (FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont_mode  (cont_mode),
    .fft        (ifc),
    .sample_adv (sample_adv),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_fcnt;

  // {start, sink_ready, source_valid, source_eop, source_error, expected outputs}
  typedef struct packed {
    logic       start;
    logic       ready;
    logic       s_valid;
    logic       s_eop;
    logic [1:0] s_err;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {sink_valid, sink_sop, sink_eop, sample_adv, busy, frame_done, err, frame_cnt}
  function automatic logic [8:0] outs();
    return {ifc.sink_valid, ifc.sink_sop, ifc.sink_eop, sample_adv, busy, frame_done, err, frame_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    start            = 1'b0;
    cont_mode        = 1'b0;
    ifc.sink_ready   = 1'b0;
    ifc.source_valid = 1'b0;
    ifc.source_eop   = 1'b0;
    ifc.source_error = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame();
    ifc.source_valid = 1'b1;
    ifc.source_eop   = 1'b1;
    tick();
    ifc.source_valid = 1'b0;
    ifc.source_eop   = 1'b0;
  endtask

  // Feeds until the eop beat is accepted (bounded); reports beat count, sop/eop positions, protocol faults
  task automatic run_frame(input bit bp, input bit poke_start, output int beats,
                           output int sop_pos, output int eop_pos, output int bad);
    logic [3:0] pat;
    logic [2:0] held;
    logic       acc;
    logic       was_eop;
    pat     = 4'b1001;
    beats   = 0;
    sop_pos = -1;
    eop_pos = -1;
    bad     = 0;
    for (int i = 0; i < 200; i++) begin
      ifc.sink_ready = bp ? pat[i[1:0]] : 1'b1;
      start = poke_start && (i == 3);
      #1;
      acc = ifc.sink_valid & ifc.sink_ready;
      if (sample_adv !== acc) bad++;
      held    = {ifc.sink_valid, ifc.sink_sop, ifc.sink_eop};
      was_eop = acc & ifc.sink_eop;
      if (acc) begin
        if (ifc.sink_sop) begin
          if (sop_pos < 0) sop_pos = beats;
          else bad++;
        end
        if (ifc.sink_eop) eop_pos = beats;
        beats++;
      end
      tick();
      if (!acc && ({ifc.sink_valid, ifc.sink_sop, ifc.sink_eop} !== held)) bad++;
      if (was_eop) break;
    end
    start = 1'b0;
    ifc.sink_ready = 1'b1;
  endtask

  initial begin
    int beats, sop_pos, eop_pos, bad, gap_seen;

    // Single shot, ready held high; stray source_eop in IDLE (with start) and in FEED
    vecs[0] = {1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 9'b1_1_0_1_1_0_0_00};
    for (int i = 1; i <= 6; i++)
      vecs[i] = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 9'b1_0_0_1_1_0_0_00};
    vecs[3] = {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 9'b1_0_0_1_1_0_0_00};
    vecs[7]  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 9'b1_0_1_1_1_0_0_00};
    vecs[8]  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 9'b0_0_0_0_1_0_0_00};
    vecs[9]  = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 9'b0_0_0_0_1_0_0_00};
    vecs[10] = {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 9'b0_0_0_0_0_1_0_01};
    vecs[11] = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 9'b0_0_0_0_0_0_0_01};

    rst_n            = 1'b0;
    start            = 1'b0;
    cont_mode        = 1'b0;
    ifc.sink_ready   = 1'b0;
    ifc.source_valid = 1'b0;
    ifc.source_eop   = 1'b0;
    ifc.source_error = 2'b00;
    tick();
    tick();
    check("reset_state", 32'(outs()), 32'(9'b0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      start            = vecs[i].start;
      ifc.sink_ready   = vecs[i].ready;
      ifc.source_valid = vecs[i].s_valid;
      ifc.source_eop   = vecs[i].s_eop;
      ifc.source_error = vecs[i].s_err;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    start            = 1'b0;
    ifc.source_valid = 1'b0;
    ifc.source_eop   = 1'b0;

    // Backpressure 1,0,0,1,...
    do_reset();
    pulse_start();
    check("bp_first_beat", 32'({ifc.sink_valid, ifc.sink_sop}), 32'(2'b11));
    run_frame(1'b1, 1'b0, beats, sop_pos, eop_pos, bad);
    check("bp_beats", beats, FL);
    check("bp_sop_pos", sop_pos, 0);
    check("bp_eop_pos", eop_pos, FL - 1);
    check("bp_protocol", bad, 0);
    check("bp_drain", 32'({ifc.sink_valid, busy}), 32'(2'b01));
    finish_frame();
    check("bp_done", 32'({frame_done, busy, frame_cnt}), 32'({1'b1, 1'b0, 2'd1}));

    // Continuous mode: three frames with 2-cycle gaps, then drop cont_mode mid-frame 4
    do_reset();
    exp_fcnt  = 0;
    cont_mode = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
      check($sformatf("cont_beats%0d", f), beats, FL);
      tick();
      finish_frame();
      exp_fcnt++;
      check($sformatf("cont_done%0d", f), 32'({frame_done, frame_cnt}), 32'({1'b1, FW'(exp_fcnt)}));
      gap_seen = 1;
      while (!ifc.sink_sop && gap_seen < 20) begin
        tick();
        gap_seen++;
      end
      check($sformatf("cont_sop_delay%0d", f), gap_seen, 3);
    end
    ifc.sink_ready = 1'b1;
    repeat (3) tick();
    cont_mode = 1'b0;
    run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
    check("cont_f4_rest", beats, FL - 3);
    check("cont_f4_eop", eop_pos, FL - 4);
    finish_frame();
    exp_fcnt++;
    check("cont_f4_done", 32'({frame_done, busy, frame_cnt}), 32'({1'b1, 1'b0, FW'(exp_fcnt)}));
    repeat (4) tick();
    check("cont_stays_idle", 32'({ifc.sink_valid, busy}), 32'(2'b00));

    // Error flag
    do_reset();
    ifc.source_valid = 1'b0;
    ifc.source_error = 2'b11;
    tick();
    check("err_needs_valid", 32'(err), 32'(1'b0));
    ifc.source_valid = 1'b1;
    ifc.source_error = 2'b01;
    tick();
    ifc.source_valid = 1'b0;
    ifc.source_error = 2'b00;
    check("err_set_idle", 32'(err), 32'(1'b1));
    pulse_start();
    check("err_clr_start", 32'(err), 32'(1'b0));
    ifc.sink_ready   = 1'b0;
    ifc.source_valid = 1'b1;
    ifc.source_error = ERR_MISSING_EOP;
    tick();
    ifc.source_valid = 1'b0;
    ifc.source_error = 2'b00;
    check("err_set_feed", 32'({err, ifc.sink_sop}), 32'(2'b11));
    run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
    check("err_frame_beats", beats, FL);
    finish_frame();
    tick();
    check("err_held", 32'({err, busy}), 32'(2'b10));
    pulse_start();
    check("err_clr2", 32'(err), 32'(1'b0));
    run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
    finish_frame();

    // Asynchronous reset mid-frame at idx=5
    do_reset();
    pulse_start();
    run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
    finish_frame();
    pulse_start();
    ifc.sink_ready   = 1'b1;
    ifc.source_valid = 1'b1;
    ifc.source_error = 2'b01;
    tick();
    ifc.source_valid = 1'b0;
    ifc.source_error = 2'b00;
    repeat (4) tick();
    check("pre_rst_state", 32'({ifc.sink_valid, err, frame_cnt}), 32'({1'b1, 1'b1, 2'd1}));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'(9'b0));
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_idle", 32'(outs()), 32'(9'b0));
    pulse_start();
    check("rst_restart_sop", 32'({ifc.sink_valid, ifc.sink_sop}), 32'(2'b11));
    run_frame(1'b0, 1'b0, beats, sop_pos, eop_pos, bad);
    check("rst_frame", 32'({beats[7:0], sop_pos[7:0], eop_pos[7:0], bad[7:0]}),
          32'({8'd8, 8'd0, 8'd7, 8'd0}));
    finish_frame();

    // Start pulses while busy are ignored; frame_cnt wraps 1,2,3,0,1
    do_reset();
    exp_fcnt = 0;
    for (int f = 0; f < 5; f++) begin
      pulse_start();
      run_frame(1'b0, 1'b1, beats, sop_pos, eop_pos, bad);
      check($sformatf("wrap_frame%0d", f), 32'({beats[7:0], sop_pos[7:0], eop_pos[7:0], bad[7:0]}),
            32'({8'd8, 8'd0, 8'd7, 8'd0}));
      pulse_start();
      check($sformatf("wrap_drain_start%0d", f), 32'({ifc.sink_valid, busy}), 32'(2'b01));
      finish_frame();
      exp_fcnt++;
      check($sformatf("wrap_cnt%0d", f), 32'({busy, frame_cnt}), 32'({1'b0, FW'(exp_fcnt)}));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
